seg7_mux_counter: RTL and testbench
===================================

Name: seg7_mux_counter

Overview:
- Parametrised multi-digit up/down counter with a multiplexed 7-segment display driver.
- A clock prescaler divides C into count ticks. The count is held as DIGITS nibbles, in BCD or hex mode.
- A free-running scan divider time-multiplexes one shared segment bus across DIGITS one-hot digit enables.
- Sits between the board clock/switches and the segment/digit pins of the display module.

Parameters:
- PRESCALE_W, 15: prescaler width; one count tick per 2^PRESCALE_W enabled clocks.
- SCAN_W, 10: scan divider width; digit index advances every 2^SCAN_W clocks.
- DIGITS, 2: number of display digits, legal range 1..8.
- BCD, 1: 1 = decimal digits 0-9 per nibble; 0 = plain binary/hex count.
- SEG_ACTIVE_LOW, 0: 1 = SEG output inverted, for common-anode displays.

Ports:
- C, input, 1: clock; all state changes on its rising edge.
- CLR, input, 1: reset, asynchronous, active-high.
- CE, input, 1: count enable; gates the prescaler only.
- UP, input, 1: direction; 1 = increment, 0 = decrement.
- LOAD, input, 1: synchronous load of LOAD_VAL into the count.
- LOAD_VAL, input, 4*DIGITS: load value, nibble i = digit i, digit 0 least significant.
- COUNT, output, 4*DIGITS: current count register.
- CARRY, output, 1: one-cycle pulse on wrap (carry out or borrow out).
- SEG, output, 8: segment pattern, bit order Dgfedcba; bit 7 is the decimal point.
- DIG_SEL, output, DIGITS: one-hot digit enable, active-high.

Behaviour:
- Reset (CLR high, asynchronous): prescaler=0, scan=0, digit index=0, COUNT=0, CARRY=0, DIG_SEL=1 (digit 0), SEG=8'h3F (8'hC0 if SEG_ACTIVE_LOW).
- Reset asserted mid-operation takes effect immediately. The first edge after release behaves as from power-up.
- Prescaler:
  - Increments on each edge while CE=1 and holds while CE=0.
  - tick = CE && prescaler==all-ones; on that edge the prescaler wraps to 0.
  - The first tick occurs on the 2^PRESCALE_W-th enabled edge after reset.
- Count step on tick, UP=1:
  - BCD mode: digit 0 increments; 9->0 ripples +1 into the next digit.
  - Hex mode: COUNT+1 modulo 2^(4*DIGITS).
  - All digits at maximum (99.. or FF..) wrap to 0, and CARRY=1 for exactly that cycle.
- Count step on tick, UP=0:
  - Mirror of UP=1 with borrow: 0->9 (BCD) or 0->F (hex) borrows from the next digit.
  - All-zero wraps to all-maximum, and CARRY=1.
- CARRY is 0 on every other cycle.
- LOAD=1: COUNT<=LOAD_VAL on that edge.
  - LOAD has priority over a simultaneous tick; that tick is dropped and CARRY stays 0.
  - The prescaler is unaffected by LOAD.
  - In BCD mode, any loaded nibble >9 is stored as 0.
- Scan:
  - The scan counter runs on every edge regardless of CE.
  - When scan==all-ones, the digit index advances (DIGITS-1 wraps to 0).
- Display outputs:
  - SEG and DIG_SEL are registered and updated every edge from the current index and COUNT. They are therefore always mutually consistent and lag COUNT by one cycle.
  - DIG_SEL = 1<<index.
  - Decode table, hex digit -> SEG (active-high): 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
  - SEG bit 7 is always 0 (1 when SEG_ACTIVE_LOW).
  - SEG_ACTIVE_LOW inverts all 8 SEG bits. DIG_SEL is never inverted.
- DIGITS=1: index is constant 0 and DIG_SEL is constant 1.

Optional Feature:
- Macro: SEG7_BLANK_EN.
- Defined: leading-zero blanking.
  - Any digit i>0 is blanked when it and all digits above it are zero. Blanked means SEG=8'h00, or 8'hFF if SEG_ACTIVE_LOW.
  - Digit 0 is never blanked. DIG_SEL scanning is unchanged.
  - Example: COUNT=8'h05 shows digit1 blank, digit0 "5".
- Undefined: all digits are always decoded, including leading zeros.

Test Plan:
- Reset values, with PRESCALE_W=2, SCAN_W=1, DIGITS=2, BCD=1: pulse CLR mid-count -> COUNT=00, CARRY=0, DIG_SEL=01, SEG=3F immediately, before any clock edge.
- Tick timing: CE=1, UP=1 -> COUNT becomes 01 on the 4th edge after release, and 02 on the 8th edge. With CE=0 for 10 edges, COUNT holds while DIG_SEL keeps toggling 01/10 every 2 edges.
- BCD carry chain: LOAD 8'h09, tick -> 10; LOAD 8'h99, tick -> 00 with CARRY=1 for exactly 1 cycle.
- Down count: UP=0, LOAD 8'h00, tick -> 99 and CARRY pulse; LOAD 8'h10, tick -> 09 with no CARRY. LOAD 8'h3C (BCD) -> COUNT=8'h30.
- LOAD vs tick: LOAD=1 with LOAD_VAL=8'h42 on the tick edge -> COUNT=42, CARRY=0, and the next tick occurs 4 enabled edges later.
- Hex mode (BCD=0), SEG_ACTIVE_LOW=1: LOAD 8'h0F, tick -> 8'h10. Digit0 selected gives SEG=~3F=C0; digit1 selected gives SEG=~06=F9. With SEG7_BLANK_EN defined and COUNT=8'h05, digit1 gives SEG=FF.

Source files
------------

// File: rtl/seg7_mux_counter.sv
// Prescaled BCD/hex up/down counter with a time-multiplexed 7-segment display driver.
// Optional build macro SEG7_BLANK_EN enables leading-zero blanking of digits above digit 0.
module seg7_mux_counter #(
    parameter int PRESCALE_W     = 15,
    parameter int SCAN_W         = 10,
    parameter int DIGITS         = 2,
    parameter bit BCD            = 1,
    parameter bit SEG_ACTIVE_LOW = 0
) (
    input  logic                  C,
    input  logic                  CLR,
    input  logic                  CE,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   COUNT,
    output logic                  CARRY,
    output logic [7:0]            SEG,
    output logic [DIGITS-1:0]     DIG_SEL
);

    localparam int         IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] NIB_MAX  = BCD ? 4'd9 : 4'd15;
    localparam logic [7:0] SEG_MASK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [PRESCALE_W-1:0] prescaler;
    logic [SCAN_W-1:0]     scan;
    logic [IDX_W-1:0]      digit_idx;
    logic                  tick;

    logic [4*DIGITS-1:0]   step_val;
    logic                  step_wrap;
    logic                  ripple;
    logic [3:0]            nib;
    logic [4*DIGITS-1:0]   load_fixed;

    logic [3:0]            sel_nib;
    logic                  blank;
    logic [7:0]            seg_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            prescaler <= '0;
        end else if (CE) begin
            prescaler <= prescaler + PRESCALE_W'(1);
        end
    end

    assign tick = CE && (&prescaler);

    // Per-digit ripple: a digit at its limit rolls over and passes the carry/borrow on.
    always_comb begin
        step_val = COUNT;
        ripple   = 1'b1;
        nib      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = COUNT[4*i +: 4];
            if (ripple) begin
                if (UP) begin
                    if (nib == NIB_MAX) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = nib + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        step_val[4*i +: 4] = NIB_MAX;
                    end else begin
                        step_val[4*i +: 4] = nib - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
        end
        step_wrap = ripple;
    end

    always_comb begin
        load_fixed = LOAD_VAL;
        for (int i = 0; i < DIGITS; i++) begin
            if (BCD && (LOAD_VAL[4*i +: 4] > 4'd9)) begin
                load_fixed[4*i +: 4] = 4'd0;
            end
        end
    end

    // A load wins over a coincident tick, so that tick neither steps nor flags a wrap.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            COUNT <= '0;
            CARRY <= 1'b0;
        end else begin
            CARRY <= 1'b0;
            if (LOAD) begin
                COUNT <= load_fixed;
            end else if (tick) begin
                COUNT <= step_val;
                CARRY <= step_wrap;
            end
        end
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            scan      <= '0;
            digit_idx <= '0;
        end else begin
            scan <= scan + SCAN_W'(1);
            if (&scan) begin
                if (digit_idx == IDX_W'(DIGITS - 1)) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        sel_nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == digit_idx) begin
                sel_nib = COUNT[4*i +: 4];
            end
        end
    end

`ifdef SEG7_BLANK_EN
    logic upper_nonzero;

    // A digit is blanked only if it and every more significant digit are zero.
    always_comb begin
        upper_nonzero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(digit_idx)) && (COUNT[4*i +: 4] != 4'd0)) begin
                upper_nonzero = 1'b1;
            end
        end
        blank = (digit_idx != '0) && !upper_nonzero;
    end
`else
    assign blank = 1'b0;
`endif

    assign seg_next = (blank ? 8'h00 : {1'b0, decode(sel_nib)}) ^ SEG_MASK;

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            SEG     <= 8'h3F ^ SEG_MASK;
            DIG_SEL <= DIGITS'(1);
        end else begin
            SEG     <= seg_next;
            DIG_SEL <= DIGITS'(1) << digit_idx;
        end
    end

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Scoreboard bench for seg7_mux_counter: a BCD instance and a hex/active-low instance share stimulus
// and are compared each cycle against an arithmetic reference model.
module tb_seg7_mux_counter;

    logic       C;
    logic       CLR;
    logic       CE;
    logic       UP;
    logic       LOAD;
    logic [7:0] LOAD_VAL;

    logic [7:0] count_b, count_h, seg_b, seg_h;
    logic       carry_b, carry_h;
    logic [1:0] dig_b, dig_h;

    seg7_mux_counter #(
        .PRESCALE_W(2), .SCAN_W(1), .DIGITS(2), .BCD(1), .SEG_ACTIVE_LOW(0)
    ) dut_bcd (
        .C(C), .CLR(CLR), .CE(CE), .UP(UP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .COUNT(count_b), .CARRY(carry_b), .SEG(seg_b), .DIG_SEL(dig_b)
    );

    seg7_mux_counter #(
        .PRESCALE_W(2), .SCAN_W(1), .DIGITS(2), .BCD(0), .SEG_ACTIVE_LOW(1)
    ) dut_hex (
        .C(C), .CLR(CLR), .CE(CE), .UP(UP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .COUNT(count_h), .CARRY(carry_h), .SEG(seg_h), .DIG_SEL(dig_h)
    );

    typedef struct packed {
        logic [7:0] count;
        logic       carry;
        logic [7:0] seg;
        logic [1:0] dig;
    } exp_t;

    typedef struct packed {
        exp_t b;
        exp_t h;
    } exp_pair_t;

    exp_pair_t sb[$];

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int n_checks = 0;
    int n_fail   = 0;

    int m_presc, m_scan, m_idx, m_val_b, m_val_h;

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int loadToVal(input bit bcd, input logic [7:0] lv);
        int hi;
        int lo;
        hi = int'(lv[7:4]);
        lo = int'(lv[3:0]);
        if (!bcd) return int'(lv);
        if (hi > 9) hi = 0;
        if (lo > 9) lo = 0;
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] valToReg(input bit bcd, input int v);
        if (bcd) return {4'(v / 10), 4'(v % 10)};
        return 8'(v);
    endfunction

    function automatic logic [7:0] expSeg(input bit bcd, input bit act_low, input int v, input int idx);
        logic [7:0] r;
        logic [7:0] reg8;
        logic [3:0] d;
        reg8 = valToReg(bcd, v);
        d    = (idx == 0) ? reg8[3:0] : reg8[7:4];
        r    = {1'b0, SEG_TBL[d]};
`ifdef SEG7_BLANK_EN
        if (idx == 1 && reg8[7:4] == 4'd0) r = 8'h00;
`endif
        if (act_low) r = ~r;
        return r;
    endfunction

    task automatic resetModel();
        m_presc = 0;
        m_scan  = 0;
        m_idx   = 0;
        m_val_b = 0;
        m_val_h = 0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_count_b"}, count_b, 8'h00);
        checkOutput({tag, "_carry_b"}, 8'(carry_b), 8'h00);
        checkOutput({tag, "_dig_b"}, 8'(dig_b), 8'h01);
        checkOutput({tag, "_seg_b"}, seg_b, 8'h3F);
        checkOutput({tag, "_count_h"}, count_h, 8'h00);
        checkOutput({tag, "_carry_h"}, 8'(carry_h), 8'h00);
        checkOutput({tag, "_dig_h"}, 8'(dig_h), 8'h01);
        checkOutput({tag, "_seg_h"}, seg_h, 8'hC0);
    endtask

    // CLR is raised between edges and checked before any edge, held across one edge, then released.
    task automatic holdReset(input string tag);
        CLR = 1'b1;
        #1;
        checkReset(tag);
        @(posedge C);
        #1;
        checkReset({tag, "_held"});
        #1;
        CLR = 1'b0;
        resetModel();
    endtask

    task automatic applyStimulus(input logic ce, input logic up, input logic load, input logic [7:0] lv);
        exp_pair_t e;
        bit        tick;
        @(negedge C);
        #1;
        CE       = ce;
        UP       = up;
        LOAD     = load;
        LOAD_VAL = lv;
        tick     = ce && (m_presc == 3);
        e.b.seg  = expSeg(1'b1, 1'b0, m_val_b, m_idx);
        e.h.seg  = expSeg(1'b0, 1'b1, m_val_h, m_idx);
        e.b.dig  = 2'(1 << m_idx);
        e.h.dig  = 2'(1 << m_idx);
        e.b.carry = 1'b0;
        e.h.carry = 1'b0;
        if (load) begin
            m_val_b = loadToVal(1'b1, lv);
            m_val_h = loadToVal(1'b0, lv);
        end else if (tick) begin
            if (up) begin
                e.b.carry = (m_val_b == 99);
                e.h.carry = (m_val_h == 255);
                m_val_b = (m_val_b + 1) % 100;
                m_val_h = (m_val_h + 1) % 256;
            end else begin
                e.b.carry = (m_val_b == 0);
                e.h.carry = (m_val_h == 0);
                m_val_b = (m_val_b + 99) % 100;
                m_val_h = (m_val_h + 255) % 256;
            end
        end
        e.b.count = valToReg(1'b1, m_val_b);
        e.h.count = valToReg(1'b0, m_val_h);
        if (ce) m_presc = (m_presc + 1) % 4;
        if (m_scan == 1) m_idx = (m_idx + 1) % 2;
        m_scan = (m_scan + 1) % 2;
        sb.push_back(e);
    endtask

    task automatic runCycles(input int n, input logic ce, input logic up);
        for (int k = 0; k < n; k++) applyStimulus(ce, up, 1'b0, 8'h00);
    endtask

    always @(negedge C) begin
        exp_pair_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("count_b", count_b, e.b.count);
            checkOutput("carry_b", 8'(carry_b), 8'(e.b.carry));
            checkOutput("seg_b", seg_b, e.b.seg);
            checkOutput("dig_b", 8'(dig_b), 8'(e.b.dig));
            checkOutput("count_h", count_h, e.h.count);
            checkOutput("carry_h", 8'(carry_h), 8'(e.h.carry));
            checkOutput("seg_h", seg_h, e.h.seg);
            checkOutput("dig_h", 8'(dig_h), 8'(e.h.dig));
        end
    end

    initial begin
        CLR      = 1'b1;
        CE       = 1'b0;
        UP       = 1'b1;
        LOAD     = 1'b0;
        LOAD_VAL = 8'h00;
        resetModel();
        holdReset("rst_init");

        $display("[TB] tick timing and CE hold");
        runCycles(8, 1'b1, 1'b1);
        runCycles(10, 1'b0, 1'b1);

        $display("[TB] reset mid-count");
        runCycles(3, 1'b1, 1'b1);
        @(negedge C);
        #2;
        holdReset("rst_mid");
        runCycles(5, 1'b1, 1'b1);

        $display("[TB] carry chain");
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h09);
        runCycles(4, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h99);
        runCycles(5, 1'b1, 1'b1);

        $display("[TB] down count and load clamp");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        runCycles(5, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h10);
        runCycles(4, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C);
        runCycles(2, 1'b0, 1'b0);

        $display("[TB] load on tick edge");
        for (int k = 0; k < 4 && m_presc != 3; k++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h42);
        runCycles(5, 1'b1, 1'b1);

        $display("[TB] hex wrap and display");
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h0F);
        runCycles(4, 1'b1, 1'b1);
        runCycles(4, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h05);
        runCycles(4, 1'b0, 1'b1);

        @(negedge C);
        #2;
        checkOutput("sb_drain", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
